// File: rtl/sseg_scan_driver.sv
// sseg_scan_driver
//
// Time-multiplexed seven-segment display driver. It scans a packed set of
// per-digit segment patterns onto one shared active-low cathode bus, with one
// active-low anode per digit.
//
// The segment data is latched into a shadow register once per frame so that
// a pattern change in the middle of a frame never tears the display. Each
// digit is preceded by a blanking gap with all anodes off, which suppresses
// ghosting.
//
// Parameters:
//   DIGITS - number of multiplexed digits (>= 1)
//   DIV    - clock cycles each digit is lit per frame (>= 1)
//   BLANK  - clock cycles with all anodes off before each digit (>= 0)
//
// Ports:
//   clk        - system clock, rising edge
//   rst        - asynchronous reset, active low
//   en         - scan enable; low keeps the display dark and the scan at digit 0
//   ssegValues - active-high segment patterns; digit k is at [7k+6:7k], bit 7k = segment a
//   digit_mask - per-digit enable; 0 keeps that anode off during its slot
//   an         - registered anodes, active low
//   seg        - registered cathodes, active low, seg[0] = segment a
//   frame_done - one-cycle pulse in the first cycle of each new frame
module sseg_scan_driver #(
    parameter int DIGITS = 4,
    parameter int DIV    = 100000,
    parameter int BLANK  = 1000
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  en,
    input  logic [7*DIGITS-1:0]   ssegValues,
    input  logic [DIGITS-1:0]     digit_mask,
    output logic [DIGITS-1:0]     an,
    output logic [6:0]            seg,
    output logic                  frame_done
);

    localparam int DIGIT_W = (DIGITS > 1) ? $clog2(DIGITS) : 1;
    localparam int TMR_MAX = (DIV > BLANK) ? DIV : BLANK;
    localparam int TMR_W   = $clog2(TMR_MAX + 1);

    localparam logic [DIGIT_W-1:0] DIGIT_LAST = DIGIT_W'(DIGITS - 1);
    localparam logic [TMR_W-1:0]   DIV_LAST   = TMR_W'(DIV - 1);
    localparam logic [TMR_W-1:0]   BLANK_LAST = TMR_W'((BLANK > 0) ? BLANK - 1 : 0);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_BLANK,
        ST_ON
    } state_t;

    // With no blanking gap every slot starts directly in the lit phase.
    localparam state_t FIRST_ST = (BLANK == 0) ? ST_ON : ST_BLANK;

    state_t                state_q, state_d;
    logic [DIGIT_W-1:0]    digit_q, digit_d;
    logic [TMR_W-1:0]      timer_q, timer_d;
    logic [7*DIGITS-1:0]   shadow_q, shadow_d;
    logic [DIGITS-1:0]     an_q, an_d;
    logic [6:0]            seg_q, seg_d;
    logic                  frame_done_q, frame_done_d;

    // Next-state logic. The outputs are derived from the next state so the
    // registered outputs always describe the phase the block is in during
    // the following cycle.
    always_comb begin
        state_d      = state_q;
        digit_d      = digit_q;
        timer_d      = timer_q;
        shadow_d     = shadow_q;
        frame_done_d = 1'b0;

        if (!en) begin
            state_d = ST_IDLE;
            digit_d = '0;
            timer_d = '0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    shadow_d = ssegValues;
                    digit_d  = '0;
                    timer_d  = '0;
                    state_d  = FIRST_ST;
                end
                ST_BLANK: begin
                    if (timer_q == BLANK_LAST) begin
                        state_d = ST_ON;
                        timer_d = '0;
                    end else begin
                        timer_d = timer_q + 1'b1;
                    end
                end
                ST_ON: begin
                    if (timer_q == DIV_LAST) begin
                        timer_d = '0;
                        state_d = FIRST_ST;
                        // Wrapping past the last digit starts a new frame,
                        // which is the only point the shadow is refreshed.
                        if (digit_q == DIGIT_LAST) begin
                            digit_d      = '0;
                            shadow_d     = ssegValues;
                            frame_done_d = 1'b1;
                        end else begin
                            digit_d = digit_q + 1'b1;
                        end
                    end else begin
                        timer_d = timer_q + 1'b1;
                    end
                end
                default: begin
                    state_d = ST_IDLE;
                    digit_d = '0;
                    timer_d = '0;
                end
            endcase
        end

        // The cathodes carry the digit's pattern even when its anode is
        // masked off; the mask is applied live every cycle.
        an_d  = '1;
        seg_d = 7'h7F;
        if (state_d == ST_ON) begin
            an_d[digit_d] = ~digit_mask[digit_d];
            seg_d         = ~shadow_d[7*int'(digit_d) +: 7];
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q      <= ST_IDLE;
            digit_q      <= '0;
            timer_q      <= '0;
            shadow_q     <= '0;
            an_q         <= '1;
            seg_q        <= 7'h7F;
            frame_done_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            digit_q      <= digit_d;
            timer_q      <= timer_d;
            shadow_q     <= shadow_d;
            an_q         <= an_d;
            seg_q        <= seg_d;
            frame_done_q <= frame_done_d;
        end
    end

    assign an         = an_q;
    assign seg        = seg_q;
    assign frame_done = frame_done_q;

endmodule

// File: tb/tb_sseg_scan_driver.sv
// Testbench for sseg_scan_driver. Two instances share all inputs: one with a
// two-cycle blanking gap and one with no gap. A cycle-count model predicts
// each instance's outputs, queues the prediction before each clock edge and
// compares it against the DUT just after the edge.
module tb_sseg_scan_driver;

   localparam int DIGITS = 4;
   localparam int DIV    = 4;

   logic                clk = 1'b0;
   logic                rst;
   logic                en;
   logic [7*DIGITS-1:0] ssegValues;
   logic [DIGITS-1:0]   digit_mask;

   logic [DIGITS-1:0]   an;
   logic [6:0]          seg;
   logic                frame_done;
   logic [DIGITS-1:0]   anNoBlank;
   logic [6:0]          segNoBlank;
   logic                frameDoneNoBlank;

   sseg_scan_driver #(.DIGITS(DIGITS), .DIV(DIV), .BLANK(2)) dut (
      .clk        (clk),
      .rst        (rst),
      .en         (en),
      .ssegValues (ssegValues),
      .digit_mask (digit_mask),
      .an         (an),
      .seg        (seg),
      .frame_done (frame_done)
   );

   sseg_scan_driver #(.DIGITS(DIGITS), .DIV(DIV), .BLANK(0)) dutNoBlank (
      .clk        (clk),
      .rst        (rst),
      .en         (en),
      .ssegValues (ssegValues),
      .digit_mask (digit_mask),
      .an         (anNoBlank),
      .seg        (segNoBlank),
      .frame_done (frameDoneNoBlank)
   );

   // 10 time-unit clock, rising edges at 5, 15, 25, ...
   always #5 clk = ~clk;

   typedef struct packed {
      logic [DIGITS-1:0] an;
      logic [6:0]        seg;
      logic              fd;
   } expect_t;

   expect_t             expQ[$];
   int                  errors = 0;
   int                  checks = 0;
   int                  cycleNum = 0;
   int                  blankOf[2] = '{2, 0};
   int                  lastFd[2] = '{-1, -1};
   bit                  modelActive = 1'b0;
   int                  modelCount = 0;
   logic [7*DIGITS-1:0] modelShadow[2];

   // Expected outputs for one variant, given the count of cycles since the
   // scan started: each slot is blank cycles followed by DIV lit cycles.
   function automatic expect_t modelOut(input int v, input bit fd);
      expect_t e;
      int slotLen;
      int pos;
      int slot;
      int w;
      slotLen = blankOf[v] + DIV;
      pos     = modelCount % (DIGITS * slotLen);
      slot    = pos / slotLen;
      w       = pos % slotLen;
      e.an    = '1;
      e.seg   = 7'h7F;
      e.fd    = fd;
      if (modelActive && w >= blankOf[v]) begin
         e.an[slot] = ~digit_mask[slot];
         e.seg      = ~modelShadow[v][slot*7 +: 7];
      end
      return e;
   endfunction

   task automatic checkOne(input string tag, input logic [DIGITS-1:0] obsAn,
                           input logic [6:0] obsSeg, input logic obsFd,
                           input int v);
      expect_t e;
      if (expQ.size() == 0) begin
         errors++;
         checks++;
         $error("[TB] FAIL %s queue empty at cycle %0d", tag, cycleNum);
         return;
      end
      e = expQ.pop_front();
      checks++;
      assert (obsAn === e.an) else begin
         errors++;
         $error("[TB] FAIL %s.an cycle %0d observed=%b expected=%b", tag, cycleNum, obsAn, e.an);
      end
      checks++;
      assert (obsSeg === e.seg) else begin
         errors++;
         $error("[TB] FAIL %s.seg cycle %0d observed=%h expected=%h", tag, cycleNum, obsSeg, e.seg);
      end
      checks++;
      assert (obsFd === e.fd) else begin
         errors++;
         $error("[TB] FAIL %s.frame_done cycle %0d observed=%b expected=%b", tag, cycleNum, obsFd, e.fd);
      end
      // Consecutive frame pulses during an uninterrupted scan must sit
      // exactly one frame period apart.
      if (obsFd === 1'b1) begin
         if (lastFd[v] >= 0) begin
            checks++;
            assert (cycleNum - lastFd[v] == DIGITS * (blankOf[v] + DIV)) else begin
               errors++;
               $error("[TB] FAIL %s.period observed=%0d expected=%0d", tag,
                      cycleNum - lastFd[v], DIGITS * (blankOf[v] + DIV));
            end
         end
         lastFd[v] = cycleNum;
      end
   endtask

   task automatic checkOutput();
      checkOne("blank2", an, seg, frame_done, 0);
      checkOne("blank0", anNoBlank, segNoBlank, frameDoneNoBlank, 1);
   endtask

   // Advance the model over the coming clock edge using the inputs the DUT
   // will sample there, queue the predictions, then clock and compare.
   task automatic applyStimulus();
      bit fd[2];
      fd[0] = 1'b0;
      fd[1] = 1'b0;
      if (!rst || !en) begin
         modelActive = 1'b0;
         lastFd[0]   = -1;
         lastFd[1]   = -1;
      end else if (!modelActive) begin
         modelActive    = 1'b1;
         modelCount     = 0;
         modelShadow[0] = ssegValues;
         modelShadow[1] = ssegValues;
      end else begin
         modelCount++;
         for (int v = 0; v < 2; v++) begin
            if (modelCount % (DIGITS * (blankOf[v] + DIV)) == 0) begin
               modelShadow[v] = ssegValues;
               fd[v]          = 1'b1;
            end
         end
      end
      for (int v = 0; v < 2; v++) expQ.push_back(modelOut(v, fd[v]));
      @(posedge clk);
      cycleNum++;
      #1;
      checkOutput();
   endtask

   task automatic runCycles(input int n);
      for (int i = 0; i < n; i++) applyStimulus();
   endtask

   task automatic pushDark();
      expect_t e;
      e.an  = '1;
      e.seg = 7'h7F;
      e.fd  = 1'b0;
      expQ.push_back(e);
      expQ.push_back(e);
   endtask

   initial begin
      rst        = 1'b0;
      en         = 1'b0;
      digit_mask = 4'hF;
      ssegValues = {7'h4F, 7'h5B, 7'h06, 7'h3F};

      // Reset state, held across a couple of edges.
      #12;
      pushDark();
      checkOutput();
      runCycles(2);
      rst = 1'b1;
      runCycles(2);

      // Basic scan, then a digit-0 change in the middle of the frame that
      // must not appear until the next frame boundary.
      en = 1'b1;
      runCycles(15);
      ssegValues[6:0] = 7'h06;
      runCycles(40);

      // Asynchronous reset during an active scan: dark with no clock edge.
      #2;
      rst = 1'b0;
      #1;
      modelActive = 1'b0;
      lastFd[0]   = -1;
      lastFd[1]   = -1;
      pushDark();
      checkOutput();
      #7;
      runCycles(1);
      #2;
      rst = 1'b1;
      #1;
      runCycles(6);

      // Masked digits keep their anodes off but the frame timing is unchanged.
      digit_mask = 4'b0101;
      runCycles(54);
      digit_mask = 4'hF;
      runCycles(3);

      // Drop enable while digit 1 of the blanked instance is lit.
      for (int i = 0; i < 30 && !((modelCount % 24) inside {[8:10]}); i++) applyStimulus();
      en = 1'b0;
      runCycles(3);
      ssegValues = {7'h08, 7'h04, 7'h02, 7'h01};
      en = 1'b1;
      runCycles(30);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule

// File: doc/sseg_scan_driver.md
# sseg_scan_driver

Time-multiplexed seven-segment display driver. It consumes the packed per-digit segment bus produced by the counter/decoder path and scans the digits onto a shared active-low cathode bus with one active-low anode per digit. Segment data is snapshotted once per frame to prevent tearing. Blanking gaps between digits suppress ghosting. This block sits between the pattern logic and the board display pins.

## Interface
Parameters:
- DIGITS, 4, number of multiplexed digits (≥1)
- DIV, 100000, clock cycles each digit is lit per frame (≥1)
- BLANK, 1000, clock cycles all anodes are off before each digit is lit (≥0)

Ports:
- clk  input  1  system clock, rising edge
- rst  input  1  asynchronous, active-low reset
- en  input  1  scan enable; low = display dark, scan held at digit 0
- ssegValues  input  7*DIGITS  segment patterns, active-high (1 = lit); digit k at bits [7k+6:7k], bit 7k+0 = segment a … bit 7k+6 = segment g; digit 0 = rightmost
- digit_mask  input  DIGITS  per-digit enable; 0 keeps that anode off during its slot
- an  output  DIGITS  anodes, active-low, registered
- seg  output  7  cathodes, active-low, registered, seg[0] = a
- frame_done  output  1  one-cycle pulse at each frame boundary

## Operation
- Registers: state {IDLE, BLANK, ON}, digit index (clog2 width, min 1), cycle timer, shadow[7*DIGITS-1:0], plus the output registers.
- Reset (rst=0, asynchronous): state IDLE, digit 0, timer 0, shadow 0, an all 1, seg 7'h7F, frame_done 0. Outputs go dark immediately, with no clock required.
- IDLE: an all 1, seg 7'h7F. When en=1 is sampled: shadow ← ssegValues, digit ← 0, timer ← 0, state ← BLANK. If BLANK=0, state goes directly to ON.
- BLANK: an all 1, seg 7'h7F for BLANK cycles, then state ← ON with timer cleared.
- ON: an[digit] = ~digit_mask[digit], all other anodes 1. seg = ~shadow[7·digit+6 : 7·digit], driven even if the digit is masked. Lasts DIV cycles.
- End of ON, digit < DIGITS-1: digit ← digit+1, state ← BLANK (or ON if BLANK=0).
- End of ON, digit = DIGITS-1: digit ← 0, shadow ← ssegValues, frame_done ← 1 for one cycle, next state BLANK (or ON if BLANK=0).
- en=0 sampled in any state: next cycle state IDLE, digit 0, timer 0, outputs dark, no frame_done. Shadow is retained but reloaded on the next start.
- Changes to ssegValues or digit_mask:
  - ssegValues changes take effect only at the next shadow load (frame start or en restart).
  - digit_mask is sampled live each cycle.
- Timer width is clog2(max(DIV, BLANK)+1). The timer never wraps within a phase.

## Timing
- Outputs are registered and reflect the current state (no combinational path from inputs to outputs).
- A first en=1 sample at edge E0 gives:
  - an all 1 for cycles E0 … E0+BLANK-1
  - digit 0 lit for cycles E0+BLANK … E0+BLANK+DIV-1
- Slot period = BLANK+DIV cycles. Frame period = DIGITS·(BLANK+DIV) cycles.
- frame_done is high during the first cycle of each new frame, which is the same cycle the new shadow takes effect. Pulses are one frame period apart.
- en deasserted: outputs dark one cycle after en=0 is sampled.
- en reasserted: scan restarts at digit 0 after the full blank phase.
- Async reset mid-ON: an/seg dark immediately. After release, the block waits in IDLE for en.

## Test plan
Bench parameters: DIGITS=4, DIV=4, BLANK=2.

1. Reset: rst=0 during an active scan → an=4'hF, seg=7'h7F, frame_done=0 immediately, asynchronous to clk.
2. Basic scan: ssegValues digits {3:7'h4F, 2:7'h5B, 1:7'h06, 0:7'h3F}, mask 4'hF, en=1.
   - an sequence: 1111×2, 1110×4, 1111×2, 1101×4, 1111×2, 1011×4, 1111×2, 0111×4, then repeats.
   - seg=7'h40 during 1110 and 7'h79 during 1101.
   - frame_done pulses every 24 cycles.
3. Anti-tearing: change digit 0 to 7'h06 during the digit-2 ON slot → digit 0 still shows 7'h40 until frame_done, then 7'h79 in the next frame.
4. Mask: digit_mask=4'b0101 → anode patterns 1101 and 0111 never appear; an=4'hF in those slots; frame period still 24.
5. Enable drop: en=0 sampled mid digit-1 ON → next cycle an=4'hF, seg=7'h7F, no frame_done. en=1 again → 2 dark cycles, then an=1110 with the freshly loaded ssegValues.
6. BLANK=0 variant: an 1110×4 → 1101×4 → 1011×4 → 0111×4 with no dark cycles; frame period 16.
